cmd_trigger_gate: RTL and testbench

- Upstream trigger conditioner for the command sequencer: turns an asynchronous external trigger into the one-cycle CMD_EXT_START_FLAG consumed by the sequencer.
- Applies a programmable delay and dead time, throttles on the sequencer's CMD_READY, and counts accepted and vetoed triggers.
- Runs entirely in the command clock domain. Configuration arrives as quasi-static ports already synchronised by the register block.

---
 rtl/cmd_trigger_pkg.sv | 29 ++
 rtl/cmd_trigger_edge_sync.sv | 27 ++
 rtl/cmd_trigger_gate.sv | 179 +++++++++++++++++
 tb/tb_cmd_trigger_gate.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_trigger_pkg.sv
// Shared types and constants for the command trigger gate and its edge synchroniser.
package cmd_trigger_pkg;

  localparam int CNT_W     = 16;
  localparam int TRG_CNT_W = 32;
  localparam logic [CNT_W-1:0] VETO_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DELAY      = 3'd1,
    ST_FIRE       = 3'd2,
    ST_WAIT_ACK   = 3'd3,
    ST_WAIT_READY = 3'd4,
    ST_DEAD       = 3'd5
  } state_t;

  // An edge veto and a fire veto may land in the same cycle, hence a 2-bit increment.
  function automatic logic [CNT_W-1:0] veto_add(input logic [CNT_W-1:0] cur,
                                                input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + {{(CNT_W-1){1'b0}}, inc};
    if (sum > {1'b0, VETO_SAT}) begin
      veto_add = VETO_SAT;
    end else begin
      veto_add = sum[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cmd_trigger_edge_sync.sv
// Multi-stage synchroniser for an asynchronous trigger followed by rising-edge detection.
module cmd_trigger_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchroniser chain plus one extra flop holding the previous synchronised level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/cmd_trigger_gate.sv
// Trigger conditioner: delay, fire, acknowledge watch and dead time before re-arming.
// Optional build macro CMD_TRIGGER_TIMESTAMP_EN adds the TRIGGER_TIMESTAMP output.
module cmd_trigger_gate
  import cmd_trigger_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 CMD_CLK,
  input  logic                 CMD_RST,
  input  logic                 TRIGGER_IN,
  input  logic                 TRIGGER_ENABLE,
  input  logic [CNT_W-1:0]     CONF_DELAY,
  input  logic [CNT_W-1:0]     CONF_DEAD_TIME,
  input  logic [TRG_CNT_W-1:0] CONF_MAX_TRIGGERS,
  input  logic                 CMD_READY,
  output logic                 CMD_EXT_START_FLAG,
  output logic [TRG_CNT_W-1:0] TRIGGER_COUNT,
  output logic [CNT_W-1:0]     VETO_COUNT,
  output logic                 BUSY,
  output logic                 DONE,
`ifdef CMD_TRIGGER_TIMESTAMP_EN
  output logic [31:0]          TRIGGER_TIMESTAMP,
`endif
  output logic                 ACK_ERROR
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACK_W-1:0]       ack_q, ack_d;
  logic                   flag_q, flag_d;
  logic [TRG_CNT_W-1:0]   trg_q, trg_d;
  logic [CNT_W-1:0]       veto_q, veto_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   edge_s, accept_s, veto_edge_s, veto_fire_s;

  cmd_trigger_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk_i   (CMD_CLK),
    .rst_i   (CMD_RST),
    .async_i (TRIGGER_IN),
    .edge_o  (edge_s)
  );

  assign accept_s = edge_s & TRIGGER_ENABLE & ~done_q;

  // Sequencing, counting and veto accounting; delay and dead time share one down-counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    flag_d      = 1'b0;
    trg_d       = trg_q;
    err_d       = err_q;
    veto_fire_s = 1'b0;
    if (accept_s && (state_q != ST_IDLE)) begin
      veto_edge_s = 1'b1;
    end else begin
      veto_edge_s = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_DELAY;
          cnt_d   = CONF_DELAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_FIRE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_FIRE: begin
        ack_d = {ACK_W{1'b0}};
        if (CMD_READY) begin
          flag_d  = 1'b1;
          trg_d   = trg_q + 32'd1;
          state_d = ST_WAIT_ACK;
        end else begin
          veto_fire_s = 1'b1;
          state_d     = ST_WAIT_READY;
        end
      end
      ST_WAIT_ACK: begin
        if (!CMD_READY) begin
          state_d = ST_WAIT_READY;
        end else if (ack_q == ACK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_WAIT_READY;
        end else begin
          ack_d = ack_q + {{(ACK_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_READY: begin
        if (CMD_READY) begin
          state_d = ST_DEAD;
          cnt_d   = CONF_DEAD_TIME;
        end else begin
          state_d = ST_WAIT_READY;
        end
      end
      ST_DEAD: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    veto_d = veto_add(veto_q, {1'b0, veto_edge_s} + {1'b0, veto_fire_s});
    busy_d = (state_d != ST_IDLE);
    done_d = (CONF_MAX_TRIGGERS != 32'd0) && (trg_q >= CONF_MAX_TRIGGERS);
  end

  // State and registered outputs.
  always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
    if (CMD_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      ack_q   <= {ACK_W{1'b0}};
      flag_q  <= 1'b0;
      trg_q   <= 32'd0;
      veto_q  <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      flag_q  <= flag_d;
      trg_q   <= trg_d;
      veto_q  <= veto_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign CMD_EXT_START_FLAG = flag_q;
  assign TRIGGER_COUNT      = trg_q;
  assign VETO_COUNT         = veto_q;
  assign BUSY               = busy_q;
  assign DONE               = done_q;
  assign ACK_ERROR          = err_q;

`ifdef CMD_TRIGGER_TIMESTAMP_EN
  logic [31:0] free_q, ts_q;

  // Free-running time base, sampled into the timestamp as the start flag is raised.
  always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
    if (CMD_RST) begin
      free_q <= 32'd0;
      ts_q   <= 32'd0;
    end else begin
      free_q <= free_q + 32'd1;
      if (flag_d) begin
        ts_q <= free_q;
      end else begin
        ts_q <= ts_q;
      end
    end
  end

  assign TRIGGER_TIMESTAMP = ts_q;
`endif

endmodule

// File: tb/tb_cmd_trigger_gate.sv
// Scoreboard bench for cmd_trigger_gate: directed scenarios plus randomized phases
// checked against a timeline-based reference model.
module tb_cmd_trigger_gate;

  localparam int MAXC   = 4096;
  localparam int INF    = 32'h3FFF_FFFF;
  localparam int ACK_TO = 4;

  logic        CMD_CLK = 1'b0;
  logic        CMD_RST, TRIGGER_IN, TRIGGER_ENABLE, CMD_READY;
  logic [15:0] CONF_DELAY, CONF_DEAD_TIME;
  logic [31:0] CONF_MAX_TRIGGERS;
  logic        CMD_EXT_START_FLAG, BUSY, DONE, ACK_ERROR;
  logic [31:0] TRIGGER_COUNT;
  logic [15:0] VETO_COUNT;
`ifdef CMD_TRIGGER_TIMESTAMP_EN
  logic [31:0] TRIGGER_TIMESTAMP;
  logic [31:0] ts_prev;
  int          ts_cyc;
  bit          have_ts;
`endif

  cmd_trigger_gate #(.SYNC_STAGES(2), .ACK_TIMEOUT(ACK_TO)) dut (
    .CMD_CLK            (CMD_CLK),
    .CMD_RST            (CMD_RST),
    .TRIGGER_IN         (TRIGGER_IN),
    .TRIGGER_ENABLE     (TRIGGER_ENABLE),
    .CONF_DELAY         (CONF_DELAY),
    .CONF_DEAD_TIME     (CONF_DEAD_TIME),
    .CONF_MAX_TRIGGERS  (CONF_MAX_TRIGGERS),
    .CMD_READY          (CMD_READY),
    .CMD_EXT_START_FLAG (CMD_EXT_START_FLAG),
    .TRIGGER_COUNT      (TRIGGER_COUNT),
    .VETO_COUNT         (VETO_COUNT),
    .BUSY               (BUSY),
    .DONE               (DONE),
`ifdef CMD_TRIGGER_TIMESTAMP_EN
    .TRIGGER_TIMESTAMP  (TRIGGER_TIMESTAMP),
`endif
    .ACK_ERROR          (ACK_ERROR)
  );

  always #5 CMD_CLK = ~CMD_CLK;

  int n_pass, n_total;
  int cyc;
  bit mon_en;
  bit prev_flag;
  int ph_flags, ph_first;

  bit pmap[MAXC];
  bit trig_h[MAXC], en_h[MAXC], rdy_h[MAXC];
  int exp_veto[MAXC], exp_cnt[MAXC];
  bit exp_err[MAXC], exp_busy[MAXC], exp_done[MAXC];

  typedef struct {
    int cyc;
    int cnt;
  } flag_t;
  flag_t fq[$];

  // Timeline model: each field is the cycle at which the gate reaches that phase.
  int m_d, m_dt, m_max;
  int m_idle_at, m_fire_at, m_ack_from, m_wr_from;

  task automatic chk(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_init();
    for (int i = 0; i < MAXC; i++) begin
      trig_h[i] = 1'b0; en_h[i] = 1'b0; rdy_h[i] = 1'b0;
      exp_veto[i] = 0; exp_cnt[i] = 0;
      exp_err[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
    end
    m_idle_at = 0; m_fire_at = INF; m_ack_from = INF; m_wr_from = INF;
    fq.delete();
  endtask

  // Derive the expected outputs of cycle k+1 from the inputs applied during cycle k.
  task automatic model_step(input int k);
    bit edge_s, idle_s, done_s;
    int nv, nc;
    bit ne;
    flag_t f;
    edge_s = (k >= 3) && trig_h[k-2] && !trig_h[k-3];
    idle_s = (k >= m_idle_at);
    done_s = exp_done[k];
    nv = exp_veto[k]; nc = exp_cnt[k]; ne = exp_err[k];
    if (edge_s && en_h[k] && !done_s) begin
      if (idle_s) begin
        m_idle_at = INF;
        m_fire_at = k + m_d + 2;
      end else begin
        nv = sat16(nv + 1);
      end
    end
    if (k == m_fire_at) begin
      m_fire_at = INF;
      if (rdy_h[k]) begin
        nc = nc + 1;
        f.cyc = k + 1; f.cnt = nc;
        fq.push_back(f);
        m_ack_from = k + 1;
      end else begin
        nv = sat16(nv + 1);
        m_wr_from = k + 1;
      end
    end else if (k >= m_ack_from) begin
      if (!rdy_h[k]) begin
        m_wr_from = k + 1; m_ack_from = INF;
      end else if (k == m_ack_from + ACK_TO - 1) begin
        ne = 1'b1; m_wr_from = k + 1; m_ack_from = INF;
      end
    end else if (k >= m_wr_from) begin
      if (rdy_h[k]) begin
        m_idle_at = k + 2 + m_dt; m_wr_from = INF;
      end
    end
    exp_veto[k+1] = nv;
    exp_cnt[k+1]  = nc;
    exp_err[k+1]  = ne;
    exp_busy[k+1] = !(k + 1 >= m_idle_at);
    exp_done[k+1] = (m_max != 0) && (exp_cnt[k] >= m_max);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    TRIGGER_IN = 1'b0;
    #1 CMD_RST = 1'b1;
    #1;
    chk("rst_flag", CMD_EXT_START_FLAG, 0);
    chk("rst_trigger_count", TRIGGER_COUNT, 0);
    chk("rst_veto_count", VETO_COUNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ack_error", ACK_ERROR, 0);
`ifdef CMD_TRIGGER_TIMESTAMP_EN
    chk("rst_timestamp", TRIGGER_TIMESTAMP, 0);
    have_ts = 1'b0;
`endif
    repeat (2) @(posedge CMD_CLK);
    #1 CMD_RST = 1'b0;
    model_init();
    cyc = 0;
    prev_flag = 1'b0;
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: pops a predicted flag whenever the DUT raises one, checks status every cycle.
  always @(negedge CMD_CLK) begin : monitor
    flag_t e;
    if (mon_en && cyc >= 1) begin
      while (fq.size() > 0 && fq[0].cyc < cyc) begin
        n_total++;
        $display("FAIL flag_missing: no flag seen, expected at cycle %0d (now %0d)", fq[0].cyc, cyc);
        void'(fq.pop_front());
      end
      if (CMD_EXT_START_FLAG) begin
        ph_flags++;
        if (ph_first < 0) ph_first = cyc;
        chk("flag_back_to_back", prev_flag, 0);
        if (fq.size() == 0) begin
          n_total++;
          $display("FAIL flag_unexpected: flag at cycle %0d, none expected", cyc);
        end else begin
          e = fq.pop_front();
          chk("flag_cycle", cyc, e.cyc);
          chk("flag_trigger_count", TRIGGER_COUNT, e.cnt);
        end
`ifdef CMD_TRIGGER_TIMESTAMP_EN
        if (have_ts) chk("timestamp_delta", TRIGGER_TIMESTAMP - ts_prev, cyc - ts_cyc);
        ts_prev = TRIGGER_TIMESTAMP; ts_cyc = cyc; have_ts = 1'b1;
`endif
      end
      chk("trigger_count", TRIGGER_COUNT, exp_cnt[cyc]);
      chk("veto_count", VETO_COUNT, exp_veto[cyc]);
      chk("busy", BUSY, exp_busy[cyc]);
      chk("done", DONE, exp_done[cyc]);
      chk("ack_error", ACK_ERROR, exp_err[cyc]);
      prev_flag = CMD_EXT_START_FLAG;
    end
  end

  // lag/len: sequencer drops READY lag cycles after each flag for len cycles (len 0: never);
  // lag < 0 picks both at random per flag. fl_lo..fl_hi forces READY low.
  task automatic run_phase(input int d, input int dt, input int mx, input int nstim,
                           input bit rnd, input int lag, input int len,
                           input int rst_at, input int fl_lo, input int fl_hi);
    int k, drop_lo, drop_hi, rl_cnt, rst_pt, s_lag, s_len;
    bit stim_on, t, en, rdy;
    CONF_DELAY = 16'(d); CONF_DEAD_TIME = 16'(dt); CONF_MAX_TRIGGERS = 32'(mx);
    TRIGGER_ENABLE = 1'b1; CMD_READY = 1'b1;
    m_d = d; m_dt = dt; m_max = mx;
    do_reset();
    ph_flags = 0; ph_first = -1;
    drop_lo = INF; drop_hi = -1; rl_cnt = 0; rst_pt = rst_at; stim_on = 1'b1;
    k = 0;
    forever begin
      if (k > 0) begin
        @(posedge CMD_CLK);
        #1;
      end
      if (k == rst_pt) begin
        do_reset();
        k = 0; rst_pt = -1; stim_on = 1'b0; drop_lo = INF; drop_hi = -1;
      end
      if (k >= nstim) stim_on = 1'b0;
      cyc = k;
      if (!stim_on || k < 3) t = 1'b0;
      else if (rnd) t = ($urandom_range(0, 99) < 12);
      else t = pmap[k];
      en = (stim_on && rnd) ? ($urandom_range(0, 99) < 85) : 1'b1;
      if (CMD_EXT_START_FLAG) begin
        s_lag = (lag < 0) ? int'($urandom_range(0, 5)) : lag;
        s_len = (lag < 0) ? int'($urandom_range(0, 8)) : len;
        if (s_len > 0) begin
          drop_lo = k + s_lag; drop_hi = k + s_lag + s_len - 1;
        end
      end
      if (stim_on && rnd && rl_cnt == 0 && $urandom_range(0, 99) < 4) rl_cnt = $urandom_range(1, 6);
      rdy = !(k >= drop_lo && k <= drop_hi) && !(k >= fl_lo && k <= fl_hi) && (rl_cnt == 0);
      if (rl_cnt > 0) rl_cnt--;
      TRIGGER_IN = t; TRIGGER_ENABLE = en; CMD_READY = rdy;
      trig_h[k] = t; en_h[k] = en; rdy_h[k] = rdy;
      model_step(k);
      if (k >= nstim && k >= m_idle_at && fq.size() == 0) break;
      if (k >= MAXC - 4) begin
        n_total++;
        $display("FAIL phase_timeout: gate not idle after %0d cycles", k);
        break;
      end
      k++;
    end
    @(negedge CMD_CLK);
    #1;
  endtask

  task automatic clear_pmap();
    for (int i = 0; i < MAXC; i++) pmap[i] = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; mon_en = 1'b0; cyc = 0;
    CMD_RST = 1'b1; TRIGGER_IN = 1'b0; TRIGGER_ENABLE = 1'b0; CMD_READY = 1'b1;
    CONF_DELAY = 16'd0; CONF_DEAD_TIME = 16'd0; CONF_MAX_TRIGGERS = 32'd0;

    // Single trigger, delay 5, dead time 10: flag at cycle 9 after first sample (cycle 13 here).
    clear_pmap(); pmap[3] = 1'b1;
    run_phase(5, 10, 0, 60, 1'b0, 2, 20, -1, -1, -1);
    chk("p1_first_flag_cycle", ph_first, 13);
    chk("p1_flags", ph_flags, 1);
    chk("p1_trigger_count", TRIGGER_COUNT, 1);
    chk("p1_veto_count", VETO_COUNT, 0);
    chk("p1_busy_end", BUSY, 0);

    // Extra edges during DELAY and during DEAD are vetoed.
    clear_pmap(); pmap[3] = 1'b1; pmap[8] = 1'b1; pmap[40] = 1'b1;
    run_phase(5, 10, 0, 60, 1'b0, 2, 20, -1, -1, -1);
    chk("p2_flags", ph_flags, 1);
    chk("p2_trigger_count", TRIGGER_COUNT, 1);
    chk("p2_veto_count", VETO_COUNT, 2);

    // READY low at FIRE: no flag, one veto, back to idle after READY and dead time.
    clear_pmap(); pmap[3] = 1'b1;
    run_phase(5, 10, 0, 40, 1'b0, 2, 20, -1, 10, 20);
    chk("p3_flags", ph_flags, 0);
    chk("p3_veto_count", VETO_COUNT, 1);
    chk("p3_trigger_count", TRIGGER_COUNT, 0);
    chk("p3_busy_end", BUSY, 0);

    // Sequencer never acknowledges.
    clear_pmap(); pmap[3] = 1'b1;
    run_phase(5, 3, 0, 40, 1'b0, 2, 0, -1, -1, -1);
    chk("p4_flags", ph_flags, 1);
    chk("p4_ack_error", ACK_ERROR, 1);

    // Trigger limit of 3 with five well-spaced edges.
    clear_pmap();
    for (int i = 0; i < 5; i++) pmap[3 + 80 * i] = 1'b1;
    run_phase(5, 10, 3, 360, 1'b0, 2, 20, -1, -1, -1);
    chk("p5_flags", ph_flags, 3);
    chk("p5_done", DONE, 1);
    chk("p5_trigger_count", TRIGGER_COUNT, 3);
    chk("p5_veto_count", VETO_COUNT, 0);

    // Asynchronous reset in the middle of DELAY.
    clear_pmap(); pmap[3] = 1'b1;
    run_phase(5, 10, 0, 40, 1'b0, 2, 20, 8, -1, -1);
    chk("p6_flags", ph_flags, 0);
    chk("p6_trigger_count", TRIGGER_COUNT, 0);

    // Zero delay and zero dead time: flag at cycle 4 after first sample (cycle 8 here).
    clear_pmap(); pmap[3] = 1'b1;
    run_phase(0, 0, 0, 30, 1'b0, 1, 3, -1, -1, -1);
    chk("p7_first_flag_cycle", ph_first, 8);
    chk("p7_flags", ph_flags, 1);

    for (int p = 0; p < 6; p++) begin
      run_phase(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)),
                500, 1'b1, -1, -1, -1, -1, -1);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
